// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit memory port: RV32I funct3 widths,
// fault cause codes, data-memory access sizes and the port FSM states.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_RANGE    = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_t;

  // Number of bytes touched by an access of the given size code.
  function automatic logic [32:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: size_bytes = 33'd1;
      SZ_HALF: size_bytes = 33'd2;
      default: size_bytes = 33'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_port_load_extend.sv
// Sign/zero extension of raw (already zero-extended) memory read data
// according to the RV32I load funct3.
module load_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] raw,
  output logic [31:0] ext
);

  // Select the extension for the load width.
  always_comb begin
    // NOTE: default assignment first so every path drives ext and no latch is inferred.
    ext = raw;
    case (funct3)
      F3_B:    ext = {{24{raw[7]}}, raw[7:0]};
      F3_H:    ext = {{16{raw[15]}}, raw[15:0]};
      F3_BU:   ext = {24'b0, raw[7:0]};
      F3_HU:   ext = {16'b0, raw[15:0]};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// MEM-stage initiator of the data-memory port: accepts one load/store,
// checks funct3, alignment and range, performs a single-cycle access and
// holds the writeback response until it is taken.
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter logic [31:0] MEM_BASE  = 32'h0100_0000,
  parameter int unsigned MEM_DEPTH = 1048576
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  output logic        mem_read_write,
  output logic [1:0]  mem_access_size,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [4:0]  resp_rd,
  output logic        resp_wb_en,
  output logic        resp_fault,
  output logic [1:0]  resp_cause
);

  // Last legal byte address, in 33 bits so the range compare cannot wrap.
  localparam logic [32:0] LIMIT = {1'b0, MEM_BASE} + 33'(MEM_DEPTH) - 33'd1;

  state_t      state;
  logic        is_store_q;
  logic [2:0]  funct3_q;
  logic [4:0]  rd_q;
  logic [31:0] ext_data;

  logic        f3_legal;
  logic        misaligned;
  logic        out_of_range;
  logic [1:0]  size_c;
  logic [32:0] last_byte;
  logic [1:0]  cause_c;

  assign req_ready = (state == ST_IDLE) && reset;
  // Write strobe only in ACCESS and never at an edge where reset is asserted.
  assign mem_read_write = (state == ST_ACCESS) && is_store_q && reset;

  assign size_c    = req_funct3[1:0];
  assign last_byte = {1'b0, req_addr} + size_bytes(size_c) - 33'd1;

  // Request checks in priority order: illegal funct3, misaligned, out of range.
  always_comb begin
    f3_legal     = req_is_store ? (req_funct3 inside {F3_B, F3_H, F3_W})
                                : (req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    misaligned   = ((size_c == SZ_HALF) && req_addr[0]) ||
                   ((size_c == SZ_WORD) && (req_addr[1:0] != 2'b00));
    out_of_range = (req_addr < MEM_BASE) || (last_byte > LIMIT);
    cause_c      = CAUSE_NONE;
    if (!f3_legal)         cause_c = CAUSE_ILLEGAL;
    else if (misaligned)   cause_c = CAUSE_MISALIGN;
    else if (out_of_range) cause_c = CAUSE_RANGE;
  end

  load_extend u_load_extend (
    .funct3 (funct3_q),
    .raw    (mem_data_out),
    .ext    (ext_data)
  );

  // Port FSM with request, memory-drive and response registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state           <= ST_IDLE;
      is_store_q      <= 1'b0;
      funct3_q        <= F3_W;
      rd_q            <= 5'd0;
      mem_address     <= MEM_BASE;
      mem_data_in     <= 32'd0;
      mem_access_size <= SZ_WORD;
      resp_valid      <= 1'b0;
      resp_rdata      <= 32'd0;
      resp_rd         <= 5'd0;
      resp_wb_en      <= 1'b0;
      resp_fault      <= 1'b0;
      resp_cause      <= CAUSE_NONE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            is_store_q <= req_is_store;
            funct3_q   <= req_funct3;
            rd_q       <= req_rd;
            if (cause_c != CAUSE_NONE) begin
              // Faults skip the memory entirely.
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_fault <= 1'b1;
              resp_cause <= cause_c;
              resp_rdata <= 32'd0;
              resp_wb_en <= 1'b0;
              resp_rd    <= req_rd;
            end else begin
              state           <= ST_ACCESS;
              mem_address     <= req_addr;
              mem_data_in     <= req_wdata;
              mem_access_size <= size_c;
            end
          end
        end
        ST_ACCESS: begin
          state      <= ST_RESP;
          resp_valid <= 1'b1;
          resp_fault <= 1'b0;
          resp_cause <= CAUSE_NONE;
          resp_rd    <= rd_q;
          resp_rdata <= is_store_q ? 32'd0 : ext_data;
          resp_wb_en <= !is_store_q && (rd_q != 5'd0);
        end
        ST_RESP: begin
          if (resp_ready) begin
            state      <= ST_IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_rd    <= 5'd0;
            resp_wb_en <= 1'b0;
            resp_fault <= 1'b0;
            resp_cause <= CAUSE_NONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port with a small byte-addressed data memory
// model (combinational read, write on the rising edge when read_write is 1).
module tb_lsu_mem_port;

  localparam logic [31:0] BASE  = 32'h0100_0000;
  localparam logic [31:0] LAST  = 32'h010F_FFFF;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;
  logic        mem_read_write;
  logic [1:0]  mem_access_size;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic        resp_wb_en;
  logic        resp_fault;
  logic [1:0]  resp_cause;

  int total = 0;
  int bad   = 0;
  int wr_count = 0;

  // 256-byte window indexed by address[7:0]; low and high ends of the
  // range alias, which the directed tests keep apart.
  logic [7:0] mem [0:255];

  lsu_mem_port #(.MEM_BASE(32'h0100_0000), .MEM_DEPTH(1048576)) dut (
    .clock           (clock),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_is_store    (req_is_store),
    .req_funct3      (req_funct3),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .req_rd          (req_rd),
    .mem_address     (mem_address),
    .mem_data_in     (mem_data_in),
    .mem_data_out    (mem_data_out),
    .mem_read_write  (mem_read_write),
    .mem_access_size (mem_access_size),
    .resp_valid      (resp_valid),
    .resp_ready      (resp_ready),
    .resp_rdata      (resp_rdata),
    .resp_rd         (resp_rd),
    .resp_wb_en      (resp_wb_en),
    .resp_fault      (resp_fault),
    .resp_cause      (resp_cause)
  );

  always #5 clock = ~clock;

  // Memory write port.
  always @(posedge clock) begin
    if (mem_read_write) begin
      wr_count <= wr_count + 1;
      mem[mem_address[7:0]] <= mem_data_in[7:0];
      if (mem_access_size != 2'b00) mem[mem_address[7:0] + 8'd1] <= mem_data_in[15:8];
      if (mem_access_size == 2'b10) begin
        mem[mem_address[7:0] + 8'd2] <= mem_data_in[23:16];
        mem[mem_address[7:0] + 8'd3] <= mem_data_in[31:24];
      end
    end
  end

  // Memory read port, zero-extended per access size.
  always_comb begin
    mem_data_out = 32'd0;
    case (mem_access_size)
      2'b00:   mem_data_out = {24'd0, mem[mem_address[7:0]]};
      2'b01:   mem_data_out = {16'd0, mem[mem_address[7:0] + 8'd1], mem[mem_address[7:0]]};
      default: mem_data_out = {mem[mem_address[7:0] + 8'd3], mem[mem_address[7:0] + 8'd2],
                               mem[mem_address[7:0] + 8'd1], mem[mem_address[7:0]]};
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one request, then wait (bounded) for resp_valid and check latency.
  task automatic issue(input string tag, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [4:0] rd, input int exp_lat);
    int lat;
    check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid    = 1'b1;
    req_is_store = st;
    req_funct3   = f3;
    req_addr     = addr;
    req_wdata    = wdata;
    req_rd       = rd;
    @(posedge clock); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 8) begin
      @(posedge clock); #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
  endtask

  // Check the held response fields, then complete the handshake.
  task automatic finish_resp(input string tag, input logic [31:0] rdata, input logic wb,
                             input logic fault, input logic [1:0] cause, input logic [4:0] rd);
    check({tag, "_rdata"}, resp_rdata, rdata);
    check({tag, "_flags"}, {22'd0, resp_valid, resp_fault, resp_cause, resp_wb_en, resp_rd, req_ready},
          {22'd0, 1'b1, fault, cause, wb, rd, 1'b0});
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
    check({tag, "_after"}, {30'd0, resp_valid, req_ready}, {30'd0, 1'b0, 1'b1});
  endtask

  int w0;

  initial begin
    reset        = 1'b0;
    req_valid    = 1'b0;
    req_is_store = 1'b0;
    req_funct3   = 3'b000;
    req_addr     = 32'd0;
    req_wdata    = 32'd0;
    req_rd       = 5'd0;
    resp_ready   = 1'b0;

    // Reset state.
    repeat (2) @(posedge clock);
    #1;
    check("rst_outputs", {25'd0, req_ready, resp_valid, resp_fault, resp_wb_en, mem_read_write, mem_access_size},
          {25'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10});
    check("rst_address", mem_address, BASE);
    check("rst_data_in", mem_data_in, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    reset = 1'b1;
    @(posedge clock); #1;

    // 1. SW then LW of the same word.
    w0 = wr_count;
    issue("sw", 1'b1, 3'b010, BASE + 32'h10, 32'hDEAD_BEEF, 5'd3, 2);
    check("sw_writes", 32'(wr_count - w0), 32'd1);
    finish_resp("sw", 32'd0, 1'b0, 1'b0, 2'b00, 5'd3);
    issue("lw", 1'b0, 3'b010, BASE + 32'h10, 32'd0, 5'd5, 2);
    finish_resp("lw", 32'hDEAD_BEEF, 1'b1, 1'b0, 2'b00, 5'd5);
    issue("lw_rd0", 1'b0, 3'b010, BASE + 32'h10, 32'd0, 5'd0, 2);
    finish_resp("lw_rd0", 32'hDEAD_BEEF, 1'b0, 1'b0, 2'b00, 5'd0);

    // 2. Byte preload via SB, then sign/zero extension.
    issue("sb3", 1'b1, 3'b000, BASE + 32'h3, 32'h0000_0080, 5'd1, 2);
    finish_resp("sb3", 32'd0, 1'b0, 1'b0, 2'b00, 5'd1);
    issue("sb2", 1'b1, 3'b000, BASE + 32'h2, 32'hFFFF_FF12, 5'd1, 2);
    finish_resp("sb2", 32'd0, 1'b0, 1'b0, 2'b00, 5'd1);
    issue("lb", 1'b0, 3'b000, BASE + 32'h3, 32'd0, 5'd7, 2);
    finish_resp("lb", 32'hFFFF_FF80, 1'b1, 1'b0, 2'b00, 5'd7);
    issue("lbu", 1'b0, 3'b100, BASE + 32'h3, 32'd0, 5'd8, 2);
    finish_resp("lbu", 32'h0000_0080, 1'b1, 1'b0, 2'b00, 5'd8);
    issue("lh", 1'b0, 3'b001, BASE + 32'h2, 32'd0, 5'd9, 2);
    finish_resp("lh", 32'hFFFF_8012, 1'b1, 1'b0, 2'b00, 5'd9);
    issue("lhu", 1'b0, 3'b101, BASE + 32'h2, 32'd0, 5'd10, 2);
    finish_resp("lhu", 32'h0000_8012, 1'b1, 1'b0, 2'b00, 5'd10);

    // 3. Misaligned accesses fault in one cycle with no memory write.
    w0 = wr_count;
    issue("lw_mis", 1'b0, 3'b010, BASE + 32'h2, 32'd0, 5'd4, 1);
    finish_resp("lw_mis", 32'd0, 1'b0, 1'b1, 2'b01, 5'd4);
    issue("sh_mis", 1'b1, 3'b001, BASE + 32'h1, 32'h0000_5555, 5'd4, 1);
    finish_resp("sh_mis", 32'd0, 1'b0, 1'b1, 2'b01, 5'd4);
    check("mis_writes", 32'(wr_count - w0), 32'd0);

    // 4. Range boundaries.
    issue("lw_low", 1'b0, 3'b010, 32'h00FF_FFFC, 32'd0, 5'd2, 1);
    finish_resp("lw_low", 32'd0, 1'b0, 1'b1, 2'b10, 5'd2);
    issue("lw_top", 1'b0, 3'b010, LAST - 32'd1, 32'd0, 5'd2, 1);
    finish_resp("lw_top", 32'd0, 1'b0, 1'b1, 2'b01, 5'd2);
    issue("lh_top", 1'b0, 3'b001, LAST, 32'd0, 5'd2, 1);
    finish_resp("lh_top", 32'd0, 1'b0, 1'b1, 2'b01, 5'd2);
    issue("lb_past", 1'b0, 3'b000, LAST + 32'd1, 32'd0, 5'd2, 1);
    finish_resp("lb_past", 32'd0, 1'b0, 1'b1, 2'b10, 5'd2);
    issue("sb_top", 1'b1, 3'b000, LAST, 32'h0000_007F, 5'd2, 2);
    finish_resp("sb_top", 32'd0, 1'b0, 1'b0, 2'b00, 5'd2);
    issue("lb_top", 1'b0, 3'b000, LAST, 32'd0, 5'd6, 2);
    finish_resp("lb_top", 32'h0000_007F, 1'b1, 1'b0, 2'b00, 5'd6);

    // 5. Illegal funct3 (beats misalignment), response held under back-pressure.
    issue("f3_011", 1'b0, 3'b011, BASE + 32'h1, 32'd0, 5'd11, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      check("hold_flags", {22'd0, resp_valid, resp_fault, resp_cause, resp_wb_en, resp_rd, req_ready},
            {22'd0, 1'b1, 1'b1, 2'b11, 1'b0, 5'd11, 1'b0});
      check("hold_rdata", resp_rdata, 32'd0);
    end
    finish_resp("f3_011", 32'd0, 1'b0, 1'b1, 2'b11, 5'd11);
    issue("st_f3_100", 1'b1, 3'b100, BASE + 32'h8, 32'd0, 5'd12, 1);
    finish_resp("st_f3_100", 32'd0, 1'b0, 1'b1, 2'b11, 5'd12);

    // 6. Reset during ACCESS of a store suppresses the write.
    w0 = wr_count;
    check("rst6_ready", {31'd0, req_ready}, 32'd1);
    req_valid    = 1'b1;
    req_is_store = 1'b1;
    req_funct3   = 3'b010;
    req_addr     = BASE + 32'h20;
    req_wdata    = 32'h1122_3344;
    req_rd       = 5'd13;
    @(posedge clock); #1;
    req_valid = 1'b0;
    check("rst6_access_we", {31'd0, mem_read_write}, 32'd1);
    reset = 1'b0;
    #1;
    check("rst6_we_gated", {31'd0, mem_read_write}, 32'd0);
    @(posedge clock); #1;
    check("rst6_writes", 32'(wr_count - w0), 32'd0);
    check("rst6_in_reset", {30'd0, req_ready, resp_valid}, 32'd0);
    reset = 1'b1;
    @(posedge clock); #1;
    check("rst6_idle", {30'd0, req_ready, resp_valid}, {30'd0, 1'b1, 1'b0});
    check("rst6_writes_end", 32'(wr_count - w0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
